// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pkg
//  Description : Shared constants for the Avalon-MM GPIO port: bus widths
//                and the word index of each register in the map.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  // Avalon-MM slave data and address widths
  localparam int AVS_DW = 32;
  localparam int AVS_AW = 3;

  typedef logic [AVS_AW-1:0] reg_idx_t;

  // Register map, word addressed
  localparam reg_idx_t REG_DATA    = 3'd0;  // read: conditioned pins, write: OUT
  localparam reg_idx_t REG_DIR     = 3'd1;  // 1 = output
  localparam reg_idx_t REG_IRQMASK = 3'd2;
  localparam reg_idx_t REG_EDGE    = 3'd3;  // write-one-to-clear capture bits
  localparam reg_idx_t REG_OUTSET  = 3'd4;  // write-one-to-set OUT, reads 0
  localparam reg_idx_t REG_OUTCLR  = 3'd5;  // write-one-to-clear OUT, reads 0
  localparam reg_idx_t REG_RISE_EN = 3'd6;
  localparam reg_idx_t REG_FALL_EN = 3'd7;

endpackage
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_debounce
//  Description : Single-bit debouncer. The output follows the input only
//                after the input has differed from the output for
//                DEBOUNCE_CYCLES consecutive clocks; any return to the old
//                value restarts the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_val;

  // Count consecutive cycles of disagreement; commit on the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_val <= 1'b0;
    end else if (din != r_val) begin
      if (r_cnt == c_cnt_last) begin
        r_val <= din;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign dout = r_val;

endmodule
`default_nettype wire

// File: rtl/avmm_gpio_port.sv
`default_nettype none
// ============================================================================
//  Module      : avmm_gpio_port
//  Description : Parametrised Avalon-MM GPIO slave with per-bit direction,
//                input synchroniser, atomic set/clear of the output
//                register, rise/fall edge capture and a maskable level IRQ.
//                Optional per-bit input debouncing is enabled by defining
//                the macro GPIO_DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module avmm_gpio_port
  import gpio_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter logic [WIDTH-1:0] RESET_OUT       = '0,
  parameter logic [WIDTH-1:0] RESET_DIR       = '1,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 1000
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [AVS_AW-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [AVS_DW-1:0] avs_writedata,
  output logic [AVS_DW-1:0] avs_readdata,
  output logic              irq,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe
);

  // Post-reset edge suppression window: long enough for the zeroed
  // synchroniser chain to fill with real pad values
  localparam int                 c_sup_w    = $clog2(SYNC_STAGES + 2);
  localparam logic [c_sup_w-1:0] c_sup_init = c_sup_w'(SYNC_STAGES + 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]   r_prev;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_dir;
  logic [WIDTH-1:0]   r_mask;
  logic [WIDTH-1:0]   r_edge;
  logic [WIDTH-1:0]   r_rise_en;
  logic [WIDTH-1:0]   r_fall_en;
  logic [c_sup_w-1:0] r_sup_cnt;
  logic               r_irq;
  logic [AVS_DW-1:0]  r_readdata;

  // --------------------------------------------------------------------------
  // Combinational nets
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  w_wdata;
  logic [WIDTH-1:0]  w_sync;
  logic [WIDTH-1:0]  w_pin;
  logic [WIDTH-1:0]  w_rise;
  logic [WIDTH-1:0]  w_fall;
  logic [WIDTH-1:0]  w_cap;
  logic [WIDTH-1:0]  w_edge_clr;
  logic [AVS_DW-1:0] w_rd_word;
  logic              w_wr_data;
  logic              w_wr_dir;
  logic              w_wr_mask;
  logic              w_wr_edge;
  logic              w_wr_set;
  logic              w_wr_clr;
  logic              w_wr_rise;
  logic              w_wr_fall;

  // Only the low WIDTH bits of a write carry meaning
  assign w_wdata = avs_writedata[WIDTH-1:0];

  if (WIDTH < AVS_DW) begin : g_unused_wdata
    logic unused_wdata_hi;
    assign unused_wdata_hi = |avs_writedata[AVS_DW-1:WIDTH];
  end

  assign w_wr_data = avs_write && (avs_address == REG_DATA);
  assign w_wr_dir  = avs_write && (avs_address == REG_DIR);
  assign w_wr_mask = avs_write && (avs_address == REG_IRQMASK);
  assign w_wr_edge = avs_write && (avs_address == REG_EDGE);
  assign w_wr_set  = avs_write && (avs_address == REG_OUTSET);
  assign w_wr_clr  = avs_write && (avs_address == REG_OUTCLR);
  assign w_wr_rise = avs_write && (avs_address == REG_RISE_EN);
  assign w_wr_fall = avs_write && (avs_address == REG_FALL_EN);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------

  // Shift pads through the synchroniser chain; stage 0 meets the async pads
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk (clk_clk),
      .rst (reset_reset),
      .din (w_sync[i]),
      .dout(w_pin[i])
    );
  end
`else
  assign w_pin = w_sync;

  // Debounce window has no meaning without the debouncers
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = (DEBOUNCE_CYCLES != 0);
`endif

  // --------------------------------------------------------------------------
  // Edge detection
  // --------------------------------------------------------------------------

  // Remember last cycle's conditioned pin for edge comparison
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_pin;
    end
  end

  // Count down the post-reset window during which captures are ignored
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sup_cnt <= c_sup_init;
    end else if (r_sup_cnt != '0) begin
      r_sup_cnt <= r_sup_cnt - 1'b1;
    end
  end

  // Output-direction bits never capture
  assign w_rise     =  w_pin & ~r_prev & r_rise_en & ~r_dir;
  assign w_fall     = ~w_pin &  r_prev & r_fall_en & ~r_dir;
  assign w_cap      = (r_sup_cnt == '0) ? (w_rise | w_fall) : '0;
  assign w_edge_clr = w_wr_edge ? w_wdata : '0;

  // Capture edges; a new edge beats a same-cycle clear on the same bit
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_edge_clr) | w_cap;
    end
  end

  // Level interrupt from any unmasked captured edge
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_edge & r_mask);
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------

  // Output register: plain load, atomic set, atomic clear
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_out <= RESET_OUT;
    end else if (w_wr_data) begin
      r_out <= w_wdata;
    end else if (w_wr_set) begin
      r_out <= r_out | w_wdata;
    end else if (w_wr_clr) begin
      r_out <= r_out & ~w_wdata;
    end
  end

  // Direction, interrupt mask and edge-enable registers
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_dir     <= RESET_DIR;
      r_mask    <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else begin
      if (w_wr_dir)  r_dir     <= w_wdata;
      if (w_wr_mask) r_mask    <= w_wdata;
      if (w_wr_rise) r_rise_en <= w_wdata;
      if (w_wr_fall) r_fall_en <= w_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------

  // Select the addressed register, zero-extended to the bus width
  always_comb begin
    w_rd_word = '0;
    case (avs_address)
      REG_DATA:    w_rd_word[WIDTH-1:0] = w_pin;
      REG_DIR:     w_rd_word[WIDTH-1:0] = r_dir;
      REG_IRQMASK: w_rd_word[WIDTH-1:0] = r_mask;
      REG_EDGE:    w_rd_word[WIDTH-1:0] = r_edge;
      REG_RISE_EN: w_rd_word[WIDTH-1:0] = r_rise_en;
      REG_FALL_EN: w_rd_word[WIDTH-1:0] = r_fall_en;
      default:     w_rd_word = '0;
    endcase
  end

  // Register read data one cycle after the strobe and hold it otherwise
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_readdata <= '0;
    end else if (avs_read) begin
      r_readdata <= w_rd_word;
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_irq;
  assign gpio_out     = r_out;
  assign gpio_oe      = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_avmm_gpio_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avmm_gpio_port
//  Description : Self-checking bench for avmm_gpio_port. Reads are scored
//                through an expectation queue drained by a monitor; a
//                register-level model tracks OUT/DIR/EDGE and pin state.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_avmm_gpio_port;
  import gpio_pkg::*;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int PIN_LAT = SYNC_STAGES + DB;

  logic              clk_clk = 1'b0;
  logic              reset_reset = 1'b1;
  logic [AVS_AW-1:0] avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [AVS_DW-1:0] avs_writedata = '0;
  logic [AVS_DW-1:0] avs_readdata;
  logic              irq;
  logic [WIDTH-1:0]  gpio_in = '0;
  logic [WIDTH-1:0]  gpio_out;
  logic [WIDTH-1:0]  gpio_oe;

  always #5 clk_clk = ~clk_clk;

  avmm_gpio_port #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .gpio_oe      (gpio_oe)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_out, m_dir, m_mask, m_edge, m_rise, m_fall, m_pin;

  function automatic void m_reset();
    m_out = '0; m_dir = '1; m_mask = '0; m_edge = '0;
    m_rise = '0; m_fall = '0; m_pin = '0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0: v[WIDTH-1:0] = m_pin;
      3'd1: v[WIDTH-1:0] = m_dir;
      3'd2: v[WIDTH-1:0] = m_mask;
      3'd3: v[WIDTH-1:0] = m_edge;
      3'd6: v[WIDTH-1:0] = m_rise;
      3'd7: v[WIDTH-1:0] = m_fall;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void m_write(input logic [2:0] a, input logic [31:0] d);
    logic [WIDTH-1:0] dw;
    dw = d[WIDTH-1:0];
    case (a)
      3'd0: m_out  = dw;
      3'd1: m_dir  = dw;
      3'd2: m_mask = dw;
      3'd3: m_edge = m_edge & ~dw;
      3'd4: m_out  = m_out | dw;
      3'd5: m_out  = m_out & ~dw;
      3'd6: m_rise = dw;
      default: m_fall = dw;
    endcase
  endfunction

  function automatic logic m_irq();
    return |(m_edge & m_mask);
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t sb_q[$];
  logic rd_pend = 1'b0;

  always @(posedge clk_clk) rd_pend <= avs_read;

  // Monitor: score read data in the cycle after each read strobe
  always @(negedge clk_clk) begin
    exp_t e;
    if (rd_pend) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read got=0x%08h", avs_readdata);
      end else begin
        e = sb_q.pop_front();
        if (avs_readdata !== e.exp) begin
          failures++;
          $display("FAIL %s got=0x%08h exp=0x%08h", e.name, avs_readdata, e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  // ---------------- bus tasks ----------------
  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    @(negedge clk_clk);
    avs_address = a;
    avs_read    = 1'b1;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk_clk);
    avs_read = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  // Write to DUT and model together
  task automatic mwr(input logic [2:0] a, input logic [31:0] d);
    wr(a, d);
    m_write(a, d);
  endtask

  // Drive new pad values, apply edge rules in the model and let them settle
  task automatic set_pins(input logic [WIDTH-1:0] v);
    m_edge = m_edge | (v & ~m_pin & m_rise & ~m_dir) | (~v & m_pin & m_fall & ~m_dir);
    m_pin  = v;
    @(negedge clk_clk);
    gpio_in = v;
    repeat (PIN_LAT + 3) @(negedge clk_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  a;
    logic [31:0] d;

    // ---- reset state ----
    m_reset();
    repeat (4) @(negedge clk_clk);
    reset_reset = 1'b0;
    repeat (PIN_LAT + 2) @(negedge clk_clk);
    chk("reset_gpio_oe", 32'(gpio_oe), 32'hFF);
    chk("reset_gpio_out", 32'(gpio_out), 32'h00);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_readdata", avs_readdata, 32'h0);
    for (int i = 0; i < 8; i++) rd(3'(i), m_read(3'(i)), $sformatf("reset_read_%0d", i));

    // ---- output register: load, set, clear ----
    mwr(REG_DATA, 32'hFFFF_FFA5);
    chk("out_load", 32'(gpio_out), 32'hA5);
    mwr(REG_OUTSET, 32'h0000_000A);
    chk("out_set", 32'(gpio_out), 32'hAF);
    mwr(REG_OUTCLR, 32'h0000_0081);
    chk("out_clr", 32'(gpio_out), 32'h2E);
    rd(REG_OUTSET, 32'h0, "outset_reads_zero");

    // ---- rising edge on bit 4 with exact capture timing ----
    mwr(REG_DIR, 32'h0F);
    mwr(REG_RISE_EN, 32'hF0);
    mwr(REG_IRQMASK, 32'h10);
    chk("dir_gpio_oe", 32'(gpio_oe), 32'h0F);
    @(negedge clk_clk);
    gpio_in = 8'h10;
    repeat (PIN_LAT - 1) @(negedge clk_clk);
    rd(REG_EDGE, 32'h00, "edge_before_capture");
    chk("irq_lags_capture", 32'(irq), 32'h0);
    m_pin  = 8'h10;
    m_edge = 8'h10;
    rd(REG_EDGE, 32'h10, "edge_rise_bit4");
    chk("irq_after_capture", 32'(irq), 32'h1);
    mwr(REG_EDGE, 32'h10);
    chk("irq_one_cycle_after_clear", 32'(irq), 32'h1);
    @(negedge clk_clk);
    chk("irq_dropped", 32'(irq), 32'h0);

    // ---- output-direction bit never captures ----
    mwr(REG_RISE_EN, 32'h01);
    set_pins(8'h11);
    set_pins(8'h10);
    rd(REG_EDGE, m_read(REG_EDGE), "edge_output_bit_ignored");

    // ---- clear and new falling edge in the same cycle: set wins ----
    mwr(REG_DIR, 32'h00);
    mwr(REG_FALL_EN, 32'h20);
    set_pins(8'h30);
    @(negedge clk_clk);
    gpio_in = 8'h10;
    repeat (PIN_LAT - 1) @(negedge clk_clk);
    wr(REG_EDGE, 32'h20);
    m_pin  = 8'h10;
    m_edge = m_edge | 8'h20;
    repeat (3) @(negedge clk_clk);
    rd(REG_EDGE, m_read(REG_EDGE), "edge_set_beats_clear");

`ifdef GPIO_DEBOUNCE_EN
    // ---- debounce: short glitch rejected, steady level accepted ----
    @(negedge clk_clk);
    gpio_in = 8'h50;
    repeat (3) @(negedge clk_clk);
    gpio_in = 8'h10;
    repeat (10) @(negedge clk_clk);
    rd(REG_DATA, 32'h10, "debounce_glitch_rejected");
    @(negedge clk_clk);
    gpio_in = 8'h50;
    repeat (PIN_LAT - 2) @(negedge clk_clk);
    rd(REG_DATA, 32'h10, "debounce_not_yet");
    rd(REG_DATA, 32'h50, "debounce_accepted");
    m_pin = 8'h50;
    repeat (4) @(negedge clk_clk);
`endif

    // ---- randomized register and pin traffic ----
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          a = 3'($urandom_range(0, 7));
          d = $urandom;
          mwr(a, d);
          chk($sformatf("rnd_out_%0d", it), 32'(gpio_out), 32'(m_out));
          chk($sformatf("rnd_oe_%0d", it), 32'(gpio_oe), 32'(m_dir));
          @(negedge clk_clk);
          chk($sformatf("rnd_irq_w_%0d", it), 32'(irq), 32'(m_irq()));
        end
        2: begin
          set_pins(WIDTH'($urandom));
          chk($sformatf("rnd_irq_p_%0d", it), 32'(irq), 32'(m_irq()));
        end
        default: begin
          a = 3'($urandom_range(0, 7));
          rd(a, m_read(a), $sformatf("rnd_read_%0d_a%0d", it, a));
        end
      endcase
    end
    for (int i = 0; i < 8; i++) rd(3'(i), m_read(3'(i)), $sformatf("final_read_%0d", i));

    // ---- pads held high across reset release ----
    @(negedge clk_clk);
    reset_reset = 1'b1;
    gpio_in     = 8'hFF;
    repeat (3) @(negedge clk_clk);
    chk("rst2_readdata", avs_readdata, 32'h0);
    chk("rst2_gpio_oe", 32'(gpio_oe), 32'hFF);
    chk("rst2_irq", 32'(irq), 32'h0);
    reset_reset   = 1'b0;
    avs_write     = 1'b1;
    avs_address   = REG_DIR;
    avs_writedata = 32'h0;
    @(negedge clk_clk);
    avs_address   = REG_RISE_EN;
    avs_writedata = 32'hFF;
    @(negedge clk_clk);
    avs_write = 1'b0;
    m_reset();
    m_dir  = '0;
    m_rise = '1;
    m_pin  = '1;
    // A debounced pin is a genuine late 0->1 transition, after the window
    m_edge = (DB != 0) ? '1 : '0;
    repeat (PIN_LAT + 4) @(negedge clk_clk);
    rd(REG_EDGE, m_read(REG_EDGE), "edge_after_reset_release");
    rd(REG_DATA, m_read(REG_DATA), "data_after_reset_release");
    chk("irq_after_reset_release", 32'(irq), 32'h0);

    repeat (3) @(negedge clk_clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/avmm_gpio_port.md
Name: avmm_gpio_port

Overview:
- Parametrised Avalon-MM GPIO peripheral; next generation of the fixed 8-bit output-only PIO on the Nios II system.
- Adds width generalisation, per-bit direction, input synchronisation, atomic set/clear, rise/fall edge capture and a maskable IRQ.
- Sits on the Nios II data master as an MM slave.
- Pad tristate is resolved at top level from gpio_out/gpio_oe.

Parameters:
- WIDTH, 8, number of GPIO bits (1..32).
- RESET_OUT, 0, reset value of the output register (WIDTH bits).
- RESET_DIR, all-ones, reset value of DIR; 1 = output, so default matches the output-only predecessor.
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- DEBOUNCE_CYCLES, 1000, stability window in clocks; used only with GPIO_DEBOUNCE_EN.

Ports:
- clk_clk  input  1  system clock.
- reset_reset  input  1  synchronous, active-high reset.
- avs_address  input  3  word register index.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data, fixed latency 1.
- irq  output  1  level interrupt.
- gpio_in  input  WIDTH  pad inputs, asynchronous.
- gpio_out  output  WIDTH  output register.
- gpio_oe  output  WIDTH  output enable, equals DIR.

Behaviour:
- One clock domain, clk_clk. Reset is synchronous and active-high on reset_reset.
- Register map (word index):
  - 0 DATA: read = conditioned pin value; write loads OUT.
  - 1 DIR.
  - 2 IRQMASK.
  - 3 EDGE: read = capture bits; write 1 clears that bit.
  - 4 OUTSET: write 1 sets OUT bits; reads 0.
  - 5 OUTCLR: write 1 clears OUT bits; reads 0.
  - 6 RISE_EN.
  - 7 FALL_EN.
- Only bits [WIDTH-1:0] are significant. Upper writedata bits are ignored; upper readdata bits read 0.
- Reset values:
  - OUT = RESET_OUT, DIR = RESET_DIR.
  - IRQMASK, EDGE, RISE_EN, FALL_EN = 0.
  - avs_readdata = 0, irq = 0, synchroniser and previous-sample flops = 0.
- Read timing: avs_readdata is registered, valid the cycle after avs_read. It holds its value otherwise. Reads have no side effects. No waitrequest.
- Write timing: takes effect on the clock edge of avs_write. gpio_out/gpio_oe reflect it the next cycle.
- Simultaneous avs_read and avs_write in the same cycle: both are performed; read returns the pre-write value.
- Input path: gpio_in passes through SYNC_STAGES flops to give the conditioned value "pin". Pin-to-DATA-read latency = SYNC_STAGES + 1 cycles.
- Edge detect: prev <= pin every cycle.
  - Rising edge on bit i: pin & ~prev & RISE_EN & ~DIR.
  - Falling edge on bit i: ~pin & prev & FALL_EN & ~DIR.
  - A detected edge sets EDGE[i]. Output-direction bits never capture.
- Post-reset suppression: edge capture is disabled for SYNC_STAGES+1 cycles after reset deasserts, using a small down-counter. This prevents spurious edges from the zeroed chain.
- EDGE clear vs. new edge in the same cycle on the same bit: set wins, so EDGE[i] = 1.
- irq = |(EDGE & IRQMASK), registered; asserts 1 cycle after capture or mask write. Clearing EDGE or the mask drops irq one cycle later.
- Changing DIR does not alter EDGE or OUT.
- Reset mid-operation: all state returns to reset values on the next edge. A pending read returns 0.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- Defined: each input bit has a debouncer after the synchroniser.
  - "pin" updates only after the synchronised value differs from "pin" for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the old value restarts that bit's counter.
  - Counter width = $clog2(DEBOUNCE_CYCLES+1). Counters reset to 0; debounced value resets to 0.
- Undefined: pin = synchroniser output. No counters are instantiated and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package gpio_pkg holds:
  - Register index constants: REG_DATA, REG_DIR, REG_IRQMASK, REG_EDGE, REG_OUTSET, REG_OUTCLR, REG_RISE_EN, REG_FALL_EN.
  - Bus width constant AVS_DW = 32.
  - Address width constant AVS_AW = 3.
- One sub-module, gpio_debounce: per-bit debouncer with parameter DEBOUNCE_CYCLES, instantiated WIDTH times under GPIO_DEBOUNCE_EN.

Test Plan:
- Reset, then read addresses 0..7 -> DIR = 0xFF, OUT = 0x00, others 0; gpio_oe = 0xFF; irq = 0.
- Write OUT = 0xA5, OUTSET 0x0A, OUTCLR 0x81 -> gpio_out = 0xA5, then 0xAF, then 0x2E. Each update is visible 1 cycle after the write.
- DIR = 0x0F, RISE_EN = 0xF0, IRQMASK = 0x10; drive gpio_in[4] 0->1 -> EDGE = 0x10 at SYNC_STAGES+1 cycles, irq = 1 one cycle later. Write EDGE = 0x10 -> irq = 0.
- Pulse gpio_in[0] while DIR[0] = 1 with RISE_EN = 0x01 -> EDGE stays 0.
- Same-cycle EDGE clear write and new falling edge on bit 5 (FALL_EN = 0x20, DIR = 0) -> EDGE[5] = 1.
- GPIO_DEBOUNCE_EN with DEBOUNCE_CYCLES = 4:
  - 3-cycle glitch on gpio_in[6] -> DATA[6] stays 0.
  - Steady high for 6 cycles -> DATA[6] = 1 after 4 stable cycles plus sync latency.
- Hold gpio_in = 0xFF across reset release with RISE_EN = 0xFF, DIR = 0 -> EDGE remains 0.
